tape_player: RTL and testbench
==============================

# tape_player

Synthesised cassette playback source for the Radio-86RK/Apogee tape input, the transmit end of the tape link whose receiver is the monitor ROM's software read loop via PPA1 port C. It fetches file bytes from the loader buffer over a request/acknowledge handshake and emits a phase-encoded (Manchester) bit stream: leader, sync byte, then file data. Its output drives `tapein`, which is currently tied to 0 in the top level.

## Interface
Parameters:
- `HALF_CLKS`, 32000: clk_sys cycles per half-bit (≈333 µs at 96 MHz); legal range 2..65535.
- `LEADER_BYTES`, 256: count of 0x00 leader bytes.
- `SYNC_BYTE`, 8'hE6: sync byte sent after the leader.

Ports:
- `clk_sys` input 1: system clock (96 MHz).
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that starts playback; ignored while `busy`.
- `stop` input 1: abort; has priority over all other inputs.
- `len` input 16: number of file bytes, sampled on an accepted `start`.
- `rd_req` output 1: byte request, held until `rd_ack`.
- `rd_addr` output 16: file byte offset, stable while `rd_req` is high.
- `rd_data` input 8: byte value, valid with `rd_ack`.
- `rd_ack` input 1: one-cycle acknowledge; any latency is allowed.
- `tape_out` output 1: registered tape level to `tapein`.
- `busy` output 1: high from the cycle after `start` until end or abort.
- `done` output 1: one-cycle pulse on normal completion only.

## Operation
- **Encoding:** each bit is sent as two half-bits. The first half is `~b`, the second half is `b`. Bytes go MSB first.
- **States:** IDLE → LEADER → SYNC → DATA → IDLE.
  - IDLE: `tape_out`=0.
  - LEADER: sends `LEADER_BYTES` × 0x00.
  - SYNC: sends `SYNC_BYTE` once.
  - DATA: sends bytes 0..len-1.
- **Prefetch:** on entering SYNC, assert `rd_req` with `rd_addr`=0. On each `rd_ack`, latch `rd_data` into a one-byte holding register. When the shifter loads from that register, `rd_addr` increments and the next request issues if more bytes remain. This gives at most one outstanding request.
- **Underrun:** if the holding register is empty when a byte boundary is reached in DATA, the FSM stalls. `tape_out` holds the last half-bit level and the half-bit counter is frozen. Transmission resumes on the cycle after `rd_ack` with a full-length first half-bit.
- **Zero length:** `len`=0 means SYNC → IDLE with `done`; no `rd_req` is ever issued.
- **Completion:** `done` pulses after the final half-bit of byte len-1 completes. `busy` falls in the same cycle and `tape_out` returns to 0.
- **Stop:** `stop` in any state goes to IDLE on the next cycle.
  - `tape_out`=0, `rd_req`=0, holding register cleared, no `done`.
  - An `rd_ack` arriving after the stop is ignored.
- **Simultaneous inputs:** `start` and `stop` in the same cycle resolve to `stop`.
- **Reset:** reset mid-operation behaves as `stop` but acts asynchronously.
- **Reset values:** `tape_out`=0, `busy`=0, `done`=0, `rd_req`=0, `rd_addr`=0, state IDLE.

## Timing
- Accepted `start` at cycle T: `busy`=1 and the first leader half-bit appear on `tape_out` at T+1.
- Each half-bit lasts exactly `HALF_CLKS` cycles.
- One byte takes 16·`HALF_CLKS` cycles.
- Total time without underrun is (LEADER_BYTES+1+len)·16·HALF_CLKS cycles from T+1 to `done`.
- The half-bit counter is 16 bits. It reloads `HALF_CLKS`-1 and advances the half-bit at 0.
- The bit counter wraps 15→0 at each byte load.
- The leader counter is 16 bits wide, so `LEADER_BYTES` up to 65535 is supported.
- `rd_addr` does not wrap. The FSM stops at len-1, so 16-bit overflow cannot occur.
- Every output is registered; there is no combinational path from input to output.

## Structure
- A shared package `tape_pkg` holds:
  - the state enum `tape_state_t` (IDLE, LEADER, SYNC, DATA);
  - the defaults `TAPE_SYNC_BYTE` = 8'hE6 and `TAPE_LEADER_BYTES` = 256.
- One sub-module, `tape_bit_shifter`, owns the 8-bit shift register, the half-bit timer and phase, and the bit counter.
  - Inputs: `load`/`byte`.
  - Outputs: `level`, `byte_done` pulse.
  - An enable input freezes it during underrun.
- The top-level FSM, prefetch register and address counter live in `tape_player`.

## Test plan
- **Leader/sync** (`HALF_CLKS`=4, `LEADER_BYTES`=2, `len`=0): `start` → 32 leader half-bits alternating 1,0 (each pair = bit 0), then E6 as halves 0,1 0,1 0,1 1,0 1,0 0,1 0,1 1,0. Then `done` at T+1+3·64 cycles; no `rd_req` is issued.
- **Data path** (`len`=2, ack latency 3, bytes 0xA5, 0x01): `rd_addr` sequence is 0,1. The stream after sync decodes to A5 01. `done` pulses once and `busy` falls in the same cycle.
- **Underrun** (ack for byte 1 delayed 100 cycles past its boundary): `tape_out` holds its level for exactly the stall length. Byte 1 then follows with full-length half-bits and decodes correctly.
- **Abort:** `stop` midway through data byte 0 → next cycle `tape_out`=0, `busy`=0, `rd_req`=0, no `done`. A late `rd_ack` has no effect. A following `start` replays from the leader.
- **Reset mid-run:** async `reset` asserted between clock edges → all outputs reach their reset values immediately.
- **Input conflicts:** `start` while `busy` is ignored, with unchanged timing. `start` and `stop` in the same cycle in IDLE leave `busy`=0.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared types and defaults for the synthesised cassette playback source.
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEADER,
    SYNC,
    DATA
  } tape_state_t;

  localparam logic [7:0] TAPE_SYNC_BYTE    = 8'hE6;
  localparam int         TAPE_LEADER_BYTES = 256;

endpackage

// File: rtl/tape_bit_shifter.sv
// Manchester byte serialiser: 8-bit shifter, half-bit timer, half-bit counter.
// Each bit goes out as ~b then b, MSB first. At the end of the last half-bit
// it freezes in place (level held, timer stopped) until the next load.
module tape_bit_shifter
  import tape_pkg::*;
#(
  parameter int HALF_CLKS = 32000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       level,
  output logic       byte_done
);

  localparam logic [15:0] HALF_RELOAD = 16'(HALF_CLKS - 1);

  logic [7:0]  sh;
  logic [15:0] half_cnt;
  logic [3:0]  hb_cnt;
  logic [3:0]  hb_nxt;
  logic [2:0]  bit_idx;
  logic        bit_val;

  // Last cycle of the final half-bit of the current byte.
  assign byte_done = en && (half_cnt == '0) && (hb_cnt == 4'd15);

  // Bit shown during the next half-bit: half-bits 2k,2k+1 carry bit 7-k.
  assign hb_nxt  = hb_cnt + 4'd1;
  assign bit_idx = ~hb_nxt[3:1];
  assign bit_val = sh[bit_idx];

  // Timer/shifter: clear beats load beats timed advance; frozen when en is low.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sh       <= '0;
      half_cnt <= '0;
      hb_cnt   <= 4'd15;
      level    <= 1'b0;
    end else if (clr) begin
      sh       <= '0;
      half_cnt <= '0;
      hb_cnt   <= 4'd15;
      level    <= 1'b0;
    end else if (load) begin
      sh       <= load_byte;
      half_cnt <= HALF_RELOAD;
      hb_cnt   <= 4'd0;
      level    <= ~load_byte[7];
    end else if (en) begin
      if (half_cnt != '0) begin
        half_cnt <= half_cnt - 16'd1;
      end else if (hb_cnt != 4'd15) begin
        half_cnt <= HALF_RELOAD;
        hb_cnt   <= hb_nxt;
        level    <= hb_nxt[0] ? bit_val : ~bit_val;
      end
    end
  end

endmodule

// File: rtl/tape_player.sv
// Tape playback source: leader, sync byte, then file bytes fetched from the
// loader buffer through a single-entry prefetch register.
module tape_player
  import tape_pkg::*;
#(
  parameter int         HALF_CLKS    = 32000,
  parameter int         LEADER_BYTES = TAPE_LEADER_BYTES,
  parameter logic [7:0] SYNC_BYTE    = TAPE_SYNC_BYTE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] len,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic        tape_out,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LEADER_LAST = 16'(LEADER_BYTES - 1);

  tape_state_t state;
  logic [15:0] leader_cnt;
  logic [15:0] len_r;
  logic [7:0]  hold_byte;
  logic        hold_valid;
  logic        stall;

  logic        sh_clr;
  logic        sh_en;
  logic        sh_load;
  logic [7:0]  sh_byte;
  logic        byte_done;

  logic        ack_ok;
  logic        avail;
  logic        need;
  logic        more;
  logic [7:0]  next_byte;

  // Only an ack answering our own request counts; stray acks are dropped.
  assign ack_ok    = rd_req && rd_ack;
  // A byte arriving on the boundary cycle is used directly, bypassing the holder.
  assign avail     = hold_valid || ack_ok;
  assign next_byte = hold_valid ? hold_byte : rd_data;
  // rd_addr counts bytes already handed to the shifter.
  assign more      = (rd_addr != len_r);
  assign need      = byte_done || stall;
  // Timer runs through leader/sync/data, frozen while waiting on an underrun.
  assign sh_en     = (state == LEADER) || (((state == SYNC) || (state == DATA)) && !stall);

  tape_bit_shifter #(
    .HALF_CLKS (HALF_CLKS)
  ) u_shifter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr       (sh_clr),
    .en        (sh_en),
    .load      (sh_load),
    .load_byte (sh_byte),
    .level     (tape_out),
    .byte_done (byte_done)
  );

  // Shifter load/clear strobes, issued on the edge that ends each byte.
  always_comb begin
    sh_clr  = 1'b0;
    sh_load = 1'b0;
    sh_byte = 8'h00;
    case (state)
      IDLE: begin
        if (start) sh_load = 1'b1;
      end
      LEADER: begin
        if (byte_done) begin
          sh_load = 1'b1;
          sh_byte = (leader_cnt == '0) ? SYNC_BYTE : 8'h00;
        end
      end
      SYNC, DATA: begin
        if (need) begin
          if (!more) begin
            sh_clr = 1'b1;
          end else if (avail) begin
            sh_load = 1'b1;
            sh_byte = next_byte;
          end
        end
      end
      default: sh_clr = 1'b1;
    endcase
    if (stop) begin
      sh_load = 1'b0;
      sh_clr  = 1'b1;
    end
  end

  // Main FSM with prefetch holder and address counter; stop overrides all.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      leader_cnt <= '0;
      len_r      <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      stall      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        rd_req     <= 1'b0;
        rd_addr    <= '0;
        hold_valid <= 1'b0;
        stall      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= LEADER;
              busy       <= 1'b1;
              leader_cnt <= LEADER_LAST;
              len_r      <= len;
              rd_addr    <= '0;
              hold_valid <= 1'b0;
              stall      <= 1'b0;
            end
          end
          LEADER: begin
            if (byte_done) begin
              if (leader_cnt == '0) begin
                state   <= SYNC;
                rd_addr <= '0;
                rd_req  <= (len_r != '0);
              end else begin
                leader_cnt <= leader_cnt - 16'd1;
              end
            end
          end
          SYNC, DATA: begin
            if (ack_ok) begin
              hold_byte  <= rd_data;
              hold_valid <= 1'b1;
              rd_req     <= 1'b0;
            end
            if (need) begin
              if (!more) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                stall <= 1'b0;
              end else if (avail) begin
                state      <= DATA;
                stall      <= 1'b0;
                hold_valid <= 1'b0;
                rd_addr    <= rd_addr + 16'd1;
                rd_req     <= ((rd_addr + 16'd1) != len_r);
              end else begin
                state <= DATA;
                stall <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_player.sv
// Scoreboard bench for tape_player: a timeline model predicts the tape level,
// busy and done for every cycle of a run; a monitor pops and compares.
module tb_tape_player;

  localparam int         H    = 4;
  localparam int         LB   = 2;
  localparam int         B    = 16 * H;
  localparam int         MAXN = 8;
  localparam logic [7:0] SB   = 8'hE6;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic [15:0] len     = '0;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        rd_ack  = 1'b0;
  logic        tape_out;
  logic        busy;
  logic        done;

  tape_player #(
    .HALF_CLKS    (H),
    .LEADER_BYTES (LB),
    .SYNC_BYTE    (SB)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .len      (len),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ack   (rd_ack),
    .tape_out (tape_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic lvl;
    logic bsy;
    logic dn;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [MAXN];
  int         lat [MAXN];
  int         req_idx;
  int         cur_len;
  int         vectors;
  int         miscompares;
  int         fail_prints;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One byte on tape: 16 half-bits of H cycles, bit b sent as ~b then b, MSB first.
  function automatic void push_byte(input logic [7:0] v);
    logic b;
    for (int k = 0; k < 16; k++) begin
      b = v[7 - k / 2];
      for (int c = 0; c < H; c++)
        exp_q.push_back(exp_t'{((k % 2) == 1) ? b : ~b, 1'b1, 1'b0});
    end
  endfunction

  // Timeline model, cycle 0 = first cycle after start is accepted.
  // Request i goes out when byte i-1 starts (byte 0: when sync starts), is
  // answered lat[i] cycles later, and byte i starts at the later of its
  // natural boundary and the cycle after its ack; the gap holds the level.
  function automatic void build(input int n);
    int r, cur, s, a;
    logic last;
    logic [7:0] sb_v;
    logic [7:0] d;
    sb_v = SB;
    for (int j = 0; j < LB; j++) push_byte(8'h00);
    push_byte(sb_v);
    r    = LB * B;
    cur  = (LB + 1) * B;
    last = sb_v[0];
    for (int i = 0; i < n; i++) begin
      a = r + lat[i];
      s = (a + 1 > cur) ? a + 1 : cur;
      for (int k = cur; k < s; k++) exp_q.push_back(exp_t'{last, 1'b1, 1'b0});
      d = mem[i];
      push_byte(d);
      last = d[0];
      r    = s;
      cur  = s + B;
    end
    exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b1});
  endfunction

  // Monitor: every cycle the DUT shows busy or done, pop and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!reset && (busy || done)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          if (fail_prints < 20)
            $display("FAIL stream_extra: tape_out=%0b busy=%0b done=%0b with nothing expected",
                     tape_out, busy, done);
          fail_prints++;
        end else begin
          e = exp_q.pop_front();
          if ({tape_out, busy, done} !== {e.lvl, e.bsy, e.dn}) begin
            miscompares++;
            if (fail_prints < 20)
              $display("FAIL stream: tape/busy/done got %b%b%b expected %b%b%b (t=%0t)",
                       tape_out, busy, done, e.lvl, e.bsy, e.dn, $time);
            fail_prints++;
          end
        end
      end
    end
  end

  // Loader buffer: answers each new request after lat[] cycles, checks rd_addr.
  initial begin : responder
    int  wait_left;
    int  cur;
    bit  pend;
    pend = 1'b0;
    cur  = 0;
    forever begin
      @(negedge clk_sys);
      rd_ack = 1'b0;
      if (pend) begin
        if (wait_left == 0) begin
          rd_ack  = 1'b1;
          rd_data = mem[cur];
          pend    = 1'b0;
        end else begin
          wait_left--;
        end
      end else if (rd_req && !reset) begin
        vectors++;
        if (req_idx >= cur_len || rd_addr !== 16'(req_idx)) begin
          miscompares++;
          $display("FAIL rd_addr: got %0d expected %0d (len %0d)", rd_addr, req_idx, cur_len);
        end
        cur = req_idx % MAXN;
        req_idx++;
        if (lat[cur] == 0) begin
          rd_ack  = 1'b1;
          rd_data = mem[cur];
        end else begin
          pend      = 1'b1;
          wait_left = lat[cur] - 1;
        end
      end
    end
  end

  // One playback run. abort_at >= 0 cuts it at that cycle with stop (or reset).
  task automatic run(input int n, input int abort_at, input bit use_reset, input int dup_start_at);
    @(negedge clk_sys);
    req_idx = 0;
    cur_len = n;
    exp_q.delete();
    build(n);
    if (abort_at >= 0)
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    len   = 16'(n);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    len   = 16'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk_sys);
      if (use_reset) begin
        #2 reset = 1'b1;
        #1;
        check("rst_tape_out", 16'(tape_out), 16'd0);
        check("rst_busy",     16'(busy),     16'd0);
        check("rst_done",     16'(done),     16'd0);
        check("rst_rd_req",   16'(rd_req),   16'd0);
        check("rst_rd_addr",  rd_addr,       16'd0);
        @(negedge clk_sys);
        reset = 1'b0;
      end else begin
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        check("stop_tape_out", 16'(tape_out), 16'd0);
        check("stop_busy",     16'(busy),     16'd0);
        check("stop_rd_req",   16'(rd_req),   16'd0);
        check("stop_done",     16'(done),     16'd0);
      end
      check("abort_consumed", 16'(exp_q.size()), 16'd0);
    end else begin
      for (int c = 0; c < 20000 && exp_q.size() != 0; c++) begin
        start = (c == dup_start_at);
        @(negedge clk_sys);
      end
      start = 1'b0;
      check("run_complete", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
      check("req_count", 16'(req_idx), 16'(n));
    end
    repeat (200) @(negedge clk_sys);
  endtask

  localparam int ABORT_AT = (LB + 1) * B + 8 * H + 1;

  initial begin : stimulus
    vectors     = 0;
    miscompares = 0;
    fail_prints = 0;
    req_idx     = 0;
    cur_len     = 0;
    for (int i = 0; i < MAXN; i++) begin
      mem[i] = 8'h00;
      lat[i] = 1;
    end
    #1;
    check("reset_tape_out", 16'(tape_out), 16'd0);
    check("reset_busy",     16'(busy),     16'd0);
    check("reset_done",     16'(done),     16'd0);
    check("reset_rd_req",   16'(rd_req),   16'd0);
    check("reset_rd_addr",  rd_addr,       16'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    // leader + sync only, zero-length file
    run(0, -1, 1'b0, -1);

    // data path
    mem[0] = 8'hA5; mem[1] = 8'h01; lat[0] = 3; lat[1] = 3;
    run(2, -1, 1'b0, -1);

    // underrun on byte 1: ack 100 cycles past its boundary
    mem[0] = 8'h3C; mem[1] = 8'h96; lat[0] = 3; lat[1] = B + 100;
    run(2, -1, 1'b0, -1);

    // abort midway through byte 0, with a late ack for byte 1
    mem[0] = 8'hF0; mem[1] = 8'h0F; mem[2] = 8'h55; lat[0] = 2; lat[1] = 40; lat[2] = 2;
    run(3, ABORT_AT, 1'b0, -1);

    // replay after abort starts from the leader
    mem[0] = 8'hC3; lat[0] = 5;
    run(1, -1, 1'b0, -1);

    // async reset mid-run
    mem[0] = 8'h81; mem[1] = 8'h7E; mem[2] = 8'hAA; lat[0] = 2; lat[1] = 40; lat[2] = 2;
    run(3, ABORT_AT, 1'b1, -1);

    // start and stop together in IDLE
    @(negedge clk_sys);
    start = 1'b1; stop = 1'b1; len = 16'd2;
    @(negedge clk_sys);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 16'(busy), 16'd0);
    repeat (3) @(negedge clk_sys);
    check("startstop_tape", 16'(tape_out), 16'd0);
    check("startstop_req",  16'(rd_req),   16'd0);

    // start while busy is ignored
    mem[0] = 8'h12; mem[1] = 8'h34; lat[0] = 0; lat[1] = 7;
    run(2, -1, 1'b0, 50);

    // randomized runs
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < MAXN; i++) begin
        mem[i] = 8'($urandom);
        lat[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(B, B + 60) : $urandom_range(0, 30);
      end
      run(n, -1, 1'b0, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
